// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline <-> hazard controller signal bundle.
// Carries ID/EX/MEM hazard sources toward the controller and the PC/pipeline
// enable, flush, HI/LO busy, trap and perf-counter controls back out.
// Modports: master = pipeline datapath side, slave = hazard_ctrl side.
interface hazard_ctrl_if;
  // ID stage sources
  logic [4:0]  ID_Rs;
  logic [4:0]  ID_Rt;
  logic        ID_UseRs;
  logic        ID_UseRt;
  logic        ID_HiLoOp;
  // EX stage sources
  logic        EX_MemtoReg;
  logic        EX_RegWr;
  logic [4:0]  EX_Rw;
  logic        EX_MdStart;
  logic        EX_MdIsDiv;
  logic        EX_BrTaken;
  // MEM stage sources
  logic        MEM_Of;
  // controls back to the pipeline
  logic        PC_En;
  logic        IFID_En;
  logic        IFID_Flush;
  logic        IDEX_Flush;
  logic        EXMEM_Flush;
  logic        MEMWB_Flush;
  logic        HiLo_Busy;
  logic        Md_Cancel;
  logic        Exc_Redirect;
  logic [31:0] Stall_Cycles;
  logic [31:0] Flush_Events;

  modport master (
    output ID_Rs, ID_Rt, ID_UseRs, ID_UseRt, ID_HiLoOp,
    output EX_MemtoReg, EX_RegWr, EX_Rw, EX_MdStart, EX_MdIsDiv, EX_BrTaken,
    output MEM_Of,
    input  PC_En, IFID_En, IFID_Flush, IDEX_Flush, EXMEM_Flush, MEMWB_Flush,
    input  HiLo_Busy, Md_Cancel, Exc_Redirect, Stall_Cycles, Flush_Events
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UseRs, ID_UseRt, ID_HiLoOp,
    input  EX_MemtoReg, EX_RegWr, EX_Rw, EX_MdStart, EX_MdIsDiv, EX_BrTaken,
    input  MEM_Of,
    output PC_En, IFID_En, IFID_Flush, IDEX_Flush, EXMEM_Flush, MEMWB_Flush,
    output HiLo_Busy, Md_Cancel, Exc_Redirect, Stall_Cycles, Flush_Events
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: single source of stall/flush decisions for the 5-stage CPU
// (load-use, HI/LO busy window, taken branch, overflow trap).
// Latency: stall/flush are combinational (act at the next edge); state,
// busy counter and Exc_Redirect are registered.
// Backpressure: stalls hold PC and IF/ID and inject a bubble into ID/EX.
// Ports: Clk, Rst_n (async active-low), hz (hazard_ctrl_if.slave).
// Optional macro HAZARD_PERF_CNT_EN builds Stall_Cycles/Flush_Events
// counters; when undefined both ports are tied to 0.
module hazard_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic         Clk,
  input  logic         Rst_n,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {RUN, MDBUSY, TRAP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             exc_q, exc_d;

  logic lu, hl;
  logic pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic md_cancel;

  always_comb begin
    lu = hz.EX_MemtoReg & hz.EX_RegWr & (hz.EX_Rw != 5'd0) &
         ((hz.ID_UseRs & (hz.ID_Rs == hz.EX_Rw)) |
          (hz.ID_UseRt & (hz.ID_Rt == hz.EX_Rw)));
    hl = (state_q == MDBUSY) & hz.ID_HiLoOp;
  end

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    md_cancel   = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    exc_d       = 1'b0;

    if (hz.MEM_Of) begin
      // Trap beats everything: squash all stages so the faulting write-back
      // never lands, and kill any MULT/DIV in flight (including one starting
      // in EX this very cycle, which is flushed by EXMEM_Flush).
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
      md_cancel   = (state_q == MDBUSY);
      state_d     = TRAP;
      cnt_d       = '0;
      exc_d       = 1'b1;
    end else if (state_q == TRAP) begin
      // Redirect cycle: the pipeline behind the trap is already bubbles.
      state_d = RUN;
    end else begin
      if (hz.EX_BrTaken) begin
        // Stalled instruction is on the wrong path anyway; squash it.
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (lu | hl) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end

      if (state_q == MDBUSY) begin
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end else if (hz.EX_MdStart) begin
        // Counter runs N-1..0 so HiLo_Busy is high for exactly N cycles.
        cnt_d   = hz.EX_MdIsDiv ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
        state_d = MDBUSY;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exc_q   <= exc_d;
    end
  end

  assign hz.PC_En        = pc_en;
  assign hz.IFID_En      = ifid_en;
  assign hz.IFID_Flush   = ifid_flush;
  assign hz.IDEX_Flush   = idex_flush;
  assign hz.EXMEM_Flush  = exmem_flush;
  assign hz.MEMWB_Flush  = memwb_flush;
  assign hz.HiLo_Busy    = (state_q == MDBUSY);
  assign hz.Md_Cancel    = md_cancel;
  assign hz.Exc_Redirect = exc_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, ~pc_en};
    flush_cnt_d = flush_cnt_q +
                  {31'd0, ifid_flush | idex_flush | exmem_flush | memwb_flush};
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.Stall_Cycles = stall_cnt_q;
  assign hz.Flush_Events = flush_cnt_q;
`else
  assign hz.Stall_Cycles = 32'd0;
  assign hz.Flush_Events = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: vector table, directed multi-cycle sequences
// and randomized traffic against a cycle-level reference model.
module tb_hazard_ctrl;

  localparam int MULN = 4;
  localparam int DIVN = 32;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  hazard_ctrl_if hz();

  hazard_ctrl #(.MUL_CYCLES(MULN), .DIV_CYCLES(DIVN), .CNT_W(6)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .hz    (hz)
  );

  typedef struct {
    logic [4:0] rs, rt, rw;
    logic use_rs, use_rt, hilo_op, memtoreg, regwr;
    logic md_start, md_div, br, of;
  } in_t;

  typedef struct {
    in_t  i;
    logic pc_en, ifid_en, ifid_flush, idex_flush;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: cycles of HI/LO busy remaining, pending trap cycle,
  // and perf-event tallies.
  int          m_busy_left;
  bit          m_trap;
  int unsigned m_stall, m_flush;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int unsigned v);
`ifdef HAZARD_PERF_CNT_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  function automatic in_t mk(input logic [4:0] rs, input logic [4:0] rt,
                             input logic use_rs, input logic use_rt,
                             input logic memtoreg, input logic regwr,
                             input logic [4:0] rw, input logic hilo, input logic br);
    in_t v;
    v.rs = rs; v.rt = rt; v.rw = rw;
    v.use_rs = use_rs; v.use_rt = use_rt; v.hilo_op = hilo;
    v.memtoreg = memtoreg; v.regwr = regwr;
    v.md_start = 1'b0; v.md_div = 1'b0; v.br = br; v.of = 1'b0;
    return v;
  endfunction

  function automatic in_t idle();
    return mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endfunction

  task automatic drive(input in_t v);
    hz.ID_Rs = v.rs; hz.ID_Rt = v.rt;
    hz.ID_UseRs = v.use_rs; hz.ID_UseRt = v.use_rt; hz.ID_HiLoOp = v.hilo_op;
    hz.EX_MemtoReg = v.memtoreg; hz.EX_RegWr = v.regwr; hz.EX_Rw = v.rw;
    hz.EX_MdStart = v.md_start; hz.EX_MdIsDiv = v.md_div;
    hz.EX_BrTaken = v.br; hz.MEM_Of = v.of;
  endtask

  task automatic model_clear();
    m_busy_left = 0; m_trap = 0; m_stall = 0; m_flush = 0;
  endtask

  // One pipeline cycle: apply inputs after the falling edge, compare every
  // output with the model, then advance the model to the following cycle.
  task automatic step(input in_t v);
    bit lu, hl, stall, busy;
    bit e_pc, e_iff, e_idf, e_late, e_can;
    @(negedge Clk);
    drive(v);
    #1;
    busy  = (m_busy_left > 0);
    lu    = v.memtoreg && v.regwr && (v.rw != 0) &&
            ((v.use_rs && v.rs == v.rw) || (v.use_rt && v.rt == v.rw));
    hl    = busy && v.hilo_op;
    e_late = v.of;
    e_can  = v.of && busy;
    stall = !v.of && !m_trap && !v.br && (lu || hl);
    e_pc  = !stall;
    e_iff = v.of || (!m_trap && v.br);
    e_idf = v.of || (!m_trap && (v.br || lu || hl));

    chk("pc_en",        hz.PC_En,        e_pc);
    chk("ifid_en",      hz.IFID_En,      e_pc);
    chk("ifid_flush",   hz.IFID_Flush,   e_iff);
    chk("idex_flush",   hz.IDEX_Flush,   e_idf);
    chk("exmem_flush",  hz.EXMEM_Flush,  e_late);
    chk("memwb_flush",  hz.MEMWB_Flush,  e_late);
    chk("hilo_busy",    hz.HiLo_Busy,    busy);
    chk("md_cancel",    hz.Md_Cancel,    e_can);
    chk("exc_redirect", hz.Exc_Redirect, m_trap);
    chk("stall_cycles", hz.Stall_Cycles, exp_cnt(m_stall));
    chk("flush_events", hz.Flush_Events, exp_cnt(m_flush));

    if (stall) m_stall++;
    if (e_iff || e_idf || e_late) m_flush++;
    if (v.of) begin
      m_trap = 1; m_busy_left = 0;
    end else if (m_trap) begin
      m_trap = 0;
    end else if (busy) begin
      m_busy_left--;
    end else if (v.md_start) begin
      m_busy_left = v.md_div ? DIVN : MULN;
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    #2;
    drive(idle());
    Rst_n = 1'b0;
    model_clear();
    @(negedge Clk);
    #2;
    Rst_n = 1'b1;
  endtask

  vec_t vt[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t v;
    drive(idle());
    model_clear();
    do_reset();

    // reset state
    #1;
    chk("rst_hilo_busy", hz.HiLo_Busy,    1'b0);
    chk("rst_exc",       hz.Exc_Redirect, 1'b0);
    chk("rst_md_cancel", hz.Md_Cancel,    1'b0);
    chk("rst_pc_en",     hz.PC_En,        1'b1);
    chk("rst_stall_cnt", hz.Stall_Cycles, 32'd0);
    chk("rst_flush_cnt", hz.Flush_Events, 32'd0);

    // combinational vectors from RUN
    vt[0] = '{i: idle(),                                                    pc_en: 1, ifid_en: 1, ifid_flush: 0, idex_flush: 0};
    vt[1] = '{i: mk(5'd5, 5'd0, 1, 0, 1, 1, 5'd5, 0, 0),                    pc_en: 0, ifid_en: 0, ifid_flush: 0, idex_flush: 1};
    vt[2] = '{i: mk(5'd0, 5'd0, 1, 0, 1, 1, 5'd0, 0, 0),                    pc_en: 1, ifid_en: 1, ifid_flush: 0, idex_flush: 0};
    vt[3] = '{i: mk(5'd5, 5'd0, 0, 0, 1, 1, 5'd5, 0, 0),                    pc_en: 1, ifid_en: 1, ifid_flush: 0, idex_flush: 0};
    vt[4] = '{i: mk(5'd1, 5'd9, 0, 1, 1, 1, 5'd9, 0, 0),                    pc_en: 0, ifid_en: 0, ifid_flush: 0, idex_flush: 1};
    vt[5] = '{i: mk(5'd5, 5'd0, 1, 0, 1, 0, 5'd5, 0, 0),                    pc_en: 1, ifid_en: 1, ifid_flush: 0, idex_flush: 0};
    vt[6] = '{i: mk(5'd5, 5'd0, 1, 0, 0, 1, 5'd5, 0, 0),                    pc_en: 1, ifid_en: 1, ifid_flush: 0, idex_flush: 0};
    vt[7] = '{i: mk(5'd5, 5'd0, 1, 0, 1, 1, 5'd5, 0, 1),                    pc_en: 1, ifid_en: 1, ifid_flush: 1, idex_flush: 1};
    vt[8] = '{i: mk(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1),                    pc_en: 1, ifid_en: 1, ifid_flush: 1, idex_flush: 1};
    vt[9] = '{i: mk(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 0),                    pc_en: 1, ifid_en: 1, ifid_flush: 0, idex_flush: 0};
    for (int k = 0; k < 10; k++) begin
      step(vt[k].i);
      chk($sformatf("vec%0d_pc_en", k),      hz.PC_En,      vt[k].pc_en);
      chk($sformatf("vec%0d_ifid_en", k),    hz.IFID_En,    vt[k].ifid_en);
      chk($sformatf("vec%0d_ifid_flush", k), hz.IFID_Flush, vt[k].ifid_flush);
      chk($sformatf("vec%0d_idex_flush", k), hz.IDEX_Flush, vt[k].idex_flush);
    end

    // MULT busy window with MFLO waiting in ID
    do_reset();
    v = idle(); v.md_start = 1; v.md_div = 0;
    step(v);
    v = idle(); v.hilo_op = 1;
    for (int c = 0; c < MULN; c++) begin
      step(v);
      chk($sformatf("mul_busy_c%0d", c),  hz.HiLo_Busy, 1'b1);
      chk($sformatf("mul_stall_c%0d", c), hz.PC_En,     1'b0);
    end
    step(v);
    chk("mul_release_busy", hz.HiLo_Busy,    1'b0);
    chk("mul_release_pc",   hz.PC_En,        1'b1);
    chk("mul_stall_total",  hz.Stall_Cycles, exp_cnt(MULN));

    // DIV aborted by overflow in busy cycle 10
    do_reset();
    v = idle(); v.md_start = 1; v.md_div = 1;
    step(v);
    for (int c = 1; c < 10; c++) step(idle());
    v = idle(); v.of = 1;
    step(v);
    chk("div_abort_cancel", hz.Md_Cancel,   1'b1);
    chk("div_abort_busy",   hz.HiLo_Busy,   1'b1);
    chk("div_abort_exmem",  hz.EXMEM_Flush, 1'b1);
    chk("div_abort_memwb",  hz.MEMWB_Flush, 1'b1);
    chk("div_abort_ifid",   hz.IFID_Flush,  1'b1);
    step(idle());
    chk("div_trap_exc",     hz.Exc_Redirect, 1'b1);
    chk("div_trap_busy",    hz.HiLo_Busy,    1'b0);
    chk("div_trap_cancel",  hz.Md_Cancel,    1'b0);
    step(idle());
    chk("div_after_exc",    hz.Exc_Redirect, 1'b0);

    // branch over load-use, then add overflow, then overflow during TRAP
    v = mk(5'd7, 5'd0, 1, 0, 1, 1, 5'd7, 0, 1);
    step(v);
    chk("pri_br_pc",    hz.PC_En,       1'b1);
    chk("pri_br_exmem", hz.EXMEM_Flush, 1'b0);
    v.of = 1;
    step(v);
    chk("pri_of_exmem", hz.EXMEM_Flush, 1'b1);
    chk("pri_of_memwb", hz.MEMWB_Flush, 1'b1);
    v = idle(); v.of = 1;
    step(v);
    chk("trap_of_exc",   hz.Exc_Redirect, 1'b1);
    chk("trap_of_flush", hz.MEMWB_Flush,  1'b1);
    step(idle());
    chk("trap_again_exc", hz.Exc_Redirect, 1'b1);
    step(idle());
    chk("trap_done_exc",  hz.Exc_Redirect, 1'b0);

    // MdStart together with overflow: trap wins, no busy window
    v = idle(); v.md_start = 1; v.of = 1;
    step(v);
    step(idle());
    chk("mdof_busy", hz.HiLo_Busy,    1'b0);
    chk("mdof_exc",  hz.Exc_Redirect, 1'b1);
    step(idle());

    // asynchronous reset in the middle of a DIV window
    v = idle(); v.md_start = 1; v.md_div = 1;
    step(v);
    v = idle(); v.hilo_op = 1;
    step(v);
    step(v);
    @(negedge Clk);
    drive(idle());
    #2;
    Rst_n = 1'b0;
    #1;
    chk("arst_busy",      hz.HiLo_Busy,    1'b0);
    chk("arst_stall_cnt", hz.Stall_Cycles, 32'd0);
    chk("arst_flush_cnt", hz.Flush_Events, 32'd0);
    chk("arst_cancel",    hz.Md_Cancel,    1'b0);
    model_clear();
    @(negedge Clk);
    #2;
    Rst_n = 1'b1;
    v = idle(); v.hilo_op = 1;
    step(v);
    chk("arst_run_pc", hz.PC_En, 1'b1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      v.rs       = 5'($urandom_range(0, 7));
      v.rt       = 5'($urandom_range(0, 7));
      v.rw       = 5'($urandom_range(0, 7));
      v.use_rs   = 1'($urandom_range(0, 1));
      v.use_rt   = 1'($urandom_range(0, 1));
      v.hilo_op  = ($urandom_range(0, 3) == 0);
      v.memtoreg = ($urandom_range(0, 2) == 0);
      v.regwr    = ($urandom_range(0, 3) != 0);
      v.br       = ($urandom_range(0, 7) == 0);
      v.of       = ($urandom_range(0, 24) == 0);
      v.md_start = (m_busy_left == 0) && !m_trap && ($urandom_range(0, 9) == 0);
      v.md_div   = ($urandom_range(0, 3) == 0);
      step(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage CPU: drives the enable and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards and taken branches, and handles overflow traps. It also owns the multi-cycle MULT/DIV busy window that guards the HI/LO registers against early MFHI/MFLO/MTHI/MTLO. It is the single source of stall/flush decisions.

## Interface
- MUL_CYCLES, 4: busy cycles for MULT/MULTU (≥2)
- DIV_CYCLES, 32: busy cycles for DIV/DIVU (≥2)
- CNT_W, 6: busy counter width; must hold DIV_CYCLES-1
- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous, active-low reset
- ID_Rs, ID_Rt  in  5  source registers of ID instruction
- ID_UseRs, ID_UseRt  in  1  ID instruction reads Rs/Rt
- ID_HiLoOp  in  1  ID instruction is MFHI/MFLO/MTHI/MTLO or MULT/DIV
- EX_MemtoReg, EX_RegWr  in  1  EX instruction is a load writing a register
- EX_Rw  in  5  EX destination register
- EX_MdStart  in  1  MULT/DIV in EX this cycle (one-cycle pulse per instruction)
- EX_MdIsDiv  in  1  qualifies EX_MdStart: 1 = divide
- EX_BrTaken  in  1  taken branch/jump resolved in EX
- MEM_Of  in  1  overflow flag of instruction in MEM
- PC_En, IFID_En  out  1  hold PC / IF/ID when 0
- IFID_Flush, IDEX_Flush, EXMEM_Flush, MEMWB_Flush  out  1  load zero (bubble) into register next edge
- HiLo_Busy  out  1  MULT/DIV in progress
- Md_Cancel  out  1  one-cycle pulse: abort MULT/DIV datapath
- Exc_Redirect  out  1  select exception vector for PC
- Stall_Cycles, Flush_Events  out  32  performance counters

## Operation
- Stall/flush outputs are combinational from inputs and state; state, counter and Exc_Redirect are registered.
- States: RUN, MDBUSY, TRAP.
- Load-use: `lu = EX_MemtoReg & EX_RegWr & EX_Rw!=0 & ((ID_UseRs & ID_Rs==EX_Rw) | (ID_UseRt & ID_Rt==EX_Rw))`. When set: PC_En=0, IFID_En=0, IDEX_Flush=1.
- HI/LO stall: `hl = HiLo_Busy & ID_HiLoOp`; same action as lu.
- Branch: EX_BrTaken → IFID_Flush=1, IDEX_Flush=1, PC_En=1. This overrides lu/hl, because the stalled instruction is squashed.
- Overflow: MEM_Of → IFID/IDEX/EXMEM/MEMWB_Flush=1 (blocks the faulting write-back). If in MDBUSY, Md_Cancel=1 the same cycle. Next state TRAP.
  - TRAP lasts one cycle with Exc_Redirect=1 and PC_En=1, then RUN.
  - MEM_Of has top priority over branch and stalls.
- Priority: MEM_Of > EX_BrTaken > (lu | hl) > none.
- MDBUSY:
  - RUN with EX_MdStart (and no MEM_Of): counter ← (EX_MdIsDiv ? DIV_CYCLES : MUL_CYCLES) − 1, state MDBUSY.
  - In MDBUSY the counter decrements each cycle; at 0 the state returns to RUN.
  - HiLo_Busy = (state==MDBUSY).
  - EX_MdStart while already busy cannot occur, because hl stalls it in ID.
- Counters: Stall_Cycles counts cycles with PC_En=0. Flush_Events counts cycles with any flush asserted. Both wrap at 2^32.

## Timing
- Reset (Rst_n=0, asynchronous): state RUN, counter 0, HiLo_Busy=0, Md_Cancel=0, Exc_Redirect=0, Stall_Cycles=0, Flush_Events=0. Combinational outputs then follow inputs with state RUN.
- Reset mid-MDBUSY aborts the busy window immediately; no Md_Cancel pulse.
- Stall/flush take effect at the next rising edge of Clk after the causing input.
- HiLo_Busy rises the edge after EX_MdStart and stays high for exactly N cycles (N = MUL_CYCLES or DIV_CYCLES). A HI/LO op in ID during those cycles stalls; it is released in the first cycle HiLo_Busy=0.
- Simultaneous EX_MdStart and MEM_Of: the trap wins; the MULT/DIV is flushed and MDBUSY is not entered.
- MEM_Of during TRAP: flush again and stay in TRAP one more cycle.

## Configuration
- HAZARD_PERF_CNT_EN defined: Stall_Cycles and Flush_Events are live 32-bit registers.
- HAZARD_PERF_CNT_EN undefined: both ports are driven constant 0 and no counter flops are built.

## Test plan
- Load-use: `lw $5` in EX (EX_MemtoReg=1, EX_Rw=5) with `add` in ID (ID_UseRs=1, ID_Rs=5) → PC_En=0, IFID_En=0, IDEX_Flush=1 for 1 cycle; same with EX_Rw=0 → no stall.
- MULT busy: EX_MdStart=1, EX_MdIsDiv=0 → HiLo_Busy high 4 cycles; MFLO held in ID 4 cycles, issued in cycle 5; Stall_Cycles=4 with macro, 0 without.
- DIV abort: EX_MdIsDiv=1, then MEM_Of=1 at busy cycle 10 → Md_Cancel pulse, all four flushes high, Exc_Redirect=1 next cycle, HiLo_Busy=0 the cycle after the abort.
- Priority: EX_BrTaken=1 with a load-use hazard → IFID_Flush=IDEX_Flush=1, PC_En=1; adding MEM_Of=1 → EXMEM_Flush=MEMWB_Flush=1 as well, then TRAP.
- Async reset in MDBUSY: drop Rst_n mid-edge → HiLo_Busy=0 immediately, counters 0, state RUN after release.
